// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Stalls the pipeline via busy_o and presents a registered result for one cycle on done_o.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    input  logic [4:0]            rd_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            rd_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [W-1:0] fix_sign_w(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] fix_sign_2w(input logic [2*W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic             neg_q, rneg_q;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;

    // Accept-time operand decode
    logic signed [W-1:0] a_s, b_s;
    logic                signed_a, signed_b, a_neg, b_neg;
    logic [W-1:0]        a_mag, b_mag;
    logic                div_zero, div_ovf, fast;
    logic [W-1:0]        fast_res;

    always_comb begin
        a_s      = src_a_i;
        b_s      = src_b_i;
        signed_a = !(funct3_i[0] && (funct3_i[1] || funct3_i[2]));
        signed_b = signed_a && (funct3_i != 3'b010);
        a_neg    = signed_a && (a_s < 0);
        b_neg    = signed_b && (b_s < 0);
        a_mag    = fix_sign_w(src_a_i, a_neg);
        b_mag    = fix_sign_w(src_b_i, b_neg);
        div_zero = funct3_i[2] && (src_b_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] && (src_a_i == MIN_S) && (&src_b_i);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_res = funct3_i[1] ? src_a_i : '1;
        else
            fast_res = funct3_i[1] ? '0 : src_a_i;
    end

    // One iteration: shift-add for multiply, restoring step for divide
    logic            is_div_q;
    logic [2*W-1:0]  mul_acc, div_acc, acc_nxt, prod;
    logic [W:0]      sh_rem, diff;
    logic            q_bit;
    logic [W-1:0]    run_res;

    always_comb begin
        is_div_q = op_q[2];
        mul_acc  = acc + (mplier[0] ? mcand : '0);
        sh_rem   = {acc[2*W-1:W], mcand[W-1]};
        diff     = sh_rem - {1'b0, mplier};
        q_bit    = ~diff[W];
        div_acc  = {(q_bit ? diff[W-1:0] : sh_rem[W-1:0]), acc[W-2:0], q_bit};
        acc_nxt  = is_div_q ? div_acc : mul_acc;
        prod     = fix_sign_2w(acc_nxt, neg_q);
        if (!is_div_q)
            run_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (op_q[1])
            run_res = fix_sign_w(acc_nxt[2*W-1:W], rneg_q);
        else
            run_res = fix_sign_w(acc_nxt[W-1:0], neg_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_nxt = fast ? DONE : RUN;
                RUN:     if (cnt == CW'(W-1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = !clr_i && (((state == IDLE) && start_i) || (state == RUN));
        done_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q   <= funct3_i;
                        rd_q   <= rd_i;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        mcand  <= {{W{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        if (fast) begin
                            result_o <= fast_res;
                            rd_o     <= rd_i;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    if (!is_div_q)
                        mplier <= mplier >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) begin
                        result_o <= run_res;
                        rd_o     <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, latency, busy/done handshake, flush and reset.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk, rst, clr_i, start_i;
    logic [2:0]   funct3_i;
    logic [W-1:0] src_a_i, src_b_i;
    logic [4:0]   rd_i;
    logic         busy_o, done_o;
    logic [W-1:0] result_o;
    logic [4:0]   rd_o;

    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] last_res;
    logic [4:0]   last_rd;

    ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .rd_i     (rd_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] rd,
                          input logic [W-1:0] exp, input int exp_lat);
        int   lat;
        logic busy_ok;
        logic got;
        @(negedge clk);
        funct3_i = f; src_a_i = a; src_b_i = b; rd_i = rd; start_i = 1'b1;
        #1;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_accept: got %b want 1", name, busy_o);
        end
        lat = 0; busy_ok = 1'b1; got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            lat++;
            start_i = 1'b0;
            if (done_o === 1'b1) got = 1'b1;
            else if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_vec++;
        if (result_o !== exp) begin
            n_bad++; $display("FAIL %s result: got %h want %h", name, result_o, exp);
        end
        n_vec++;
        if (rd_o !== rd) begin
            n_bad++; $display("FAIL %s rd: got %0d want %0d", name, rd_o, rd);
        end
        n_vec++;
        if (busy_ok !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL %s busy_run: got run_ok=%b done_busy=%b want 1/0", name, busy_ok, busy_o);
        end
        last_res = exp;
        last_rd  = rd;
        @(negedge clk);
        n_vec++;
        if (done_o !== 1'b0) begin
            n_bad++; $display("FAIL %s done_pulse: got %b want 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_i = 1'b0; start_i = 1'b0;
        funct3_i = '0; src_a_i = '0; src_b_i = '0; rd_i = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0 || rd_o !== '0) begin
            n_bad++;
            $display("FAIL reset: got done=%b busy=%b res=%h rd=%0d want 0 0 0 0", done_o, busy_o, result_o, rd_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 33);
        run_op("mul_pp", 3'b000, 32'd1234,      32'd5678,      5'd5, 32'd7006652,   33);
    endtask

    task automatic test_div();
        run_op("div",  3'b100, 32'hFFFF_FFEC, 32'd6, 5'd6,  32'hFFFF_FFFD, 33);
        run_op("rem",  3'b110, 32'hFFFF_FFEC, 32'd6, 5'd7,  32'hFFFF_FFFE, 33);
        run_op("divu", 3'b101, 32'd100,       32'd7, 5'd8,  32'd14,        33);
        run_op("remu", 3'b111, 32'd100,       32'd7, 5'd9,  32'd2,         33);
        run_op("divu_big", 3'b101, 32'hFFFF_FFEC, 32'd6, 5'd10, 32'h2AAA_AAA7, 33);
    endtask

    task automatic test_fast_path();
        run_op("divu_z",  3'b101, 32'd5,        32'd0,        5'd11, 32'hFFFF_FFFF, 1);
        run_op("remu_z",  3'b111, 32'd5,        32'd0,        5'd12, 32'd5,         1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);
        run_op("rem_z_s", 3'b110, 32'hFFFF_FFEC, 32'd0,        5'd15, 32'hFFFF_FFEC, 1);
    endtask

    task automatic test_clear();
        int   done_at;
        int   spurious;
        done_at = -1; spurious = 0;
        for (int c = 0; c <= 55; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 12 && done_o !== 1'b0) spurious++;
            if (c > 12 && done_o === 1'b1 && done_at < 0) begin
                done_at = c;
                n_vec++;
                if (result_o !== 32'd14 || rd_o !== 5'd17) begin
                    n_bad++; $display("FAIL clr_restart_result: got %h/%0d want 0000000e/17", result_o, rd_o);
                end
            end
            if (c == 11) begin
                n_vec++;
                if (busy_o !== 1'b0) begin
                    n_bad++; $display("FAIL clr_busy: got %b want 0", busy_o);
                end
                n_vec++;
                if (result_o !== last_res || rd_o !== last_rd) begin
                    n_bad++; $display("FAIL clr_hold: got %h/%0d want %h/%0d", result_o, rd_o, last_res, last_rd);
                end
            end
            case (c)
                0: begin funct3_i = 3'b100; src_a_i = 32'hFFFF_FFEC; src_b_i = 32'd6; rd_i = 5'd16; start_i = 1'b1; end
                1: start_i = 1'b0;
                10: clr_i = 1'b1;
                11: clr_i = 1'b0;
                12: begin funct3_i = 3'b101; src_a_i = 32'd100; src_b_i = 32'd7; rd_i = 5'd17; start_i = 1'b1; end
                13: start_i = 1'b0;
                default: ;
            endcase
        end
        n_vec++;
        if (spurious != 0) begin
            n_bad++; $display("FAIL clr_no_done: got %0d pulses want 0", spurious);
        end
        n_vec++;
        if (done_at != 45) begin
            n_bad++; $display("FAIL clr_restart_latency: got cycle %0d want 45", done_at);
        end
        last_res = 32'd14; last_rd = 5'd17;
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            exp_done = (c == 33) || (c == 35);
            n_vec++;
            if (done_o !== exp_done) begin
                n_bad++; $display("FAIL b2b_done c%0d: got %b want %b", c, done_o, exp_done);
            end
            if (c == 33) begin
                n_vec++;
                if (result_o !== 32'd15 || rd_o !== 5'd20) begin
                    n_bad++; $display("FAIL b2b_res1: got %h/%0d want 0000000f/20", result_o, rd_o);
                end
            end
            if (c == 35) begin
                n_vec++;
                if (result_o !== 32'hFFFF_FFFF || rd_o !== 5'd21) begin
                    n_bad++; $display("FAIL b2b_res2: got %h/%0d want ffffffff/21", result_o, rd_o);
                end
            end
            case (c)
                0:  begin funct3_i = 3'b000; src_a_i = 32'd3; src_b_i = 32'd5; rd_i = 5'd20; start_i = 1'b1; end
                34: begin funct3_i = 3'b101; src_a_i = 32'd9; src_b_i = 32'd0; rd_i = 5'd21; end
                36: start_i = 1'b0;
                default: ;
            endcase
        end
        last_res = 32'hFFFF_FFFF; last_rd = 5'd21;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        funct3_i = 3'b000; src_a_i = 32'd7; src_b_i = 32'd9; rd_i = 5'd25; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0 || rd_o !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_run: got done=%b busy=%b res=%h rd=%0d want 0 0 0 0", done_o, busy_o, result_o, rd_o);
        end
        rst = 1'b0;
        run_op("post_rst", 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd26, 32'd1, 33);
    endtask

    initial begin
        last_res = '0;
        last_rd  = '0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_clear();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
